// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin grant, IDLE/SETUP/ACCESS
// sequencing, two-slave decode on the paddr MSB and an ACCESS timeout abort.
//
// state  | meaning
// IDLE   | bus parked, psel/penable low, waiting for an eligible request
// SETUP  | single cycle with psel high, address/control presented
// ACCESS | penable high, waiting for pready or the timeout terminal count
module apb_master_arbiter #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          done0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          psel1,
    output logic          psel2,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic          pready1,
    input  logic          pready2,
    input  logic [DW-1:0] prdata1,
    input  logic [DW-1:0] prdata2,
    input  logic          pslverr1,
    input  logic          pslverr2
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic            gnt;
    logic            rr;
    logic [CW-1:0]   cnt;
    logic            done_pend;
    logic            pend_id;
    logic            pend_err;
    logic            pend_rd;
    logic [DW-1:0]   pend_rdata;

    logic            elig0;
    logic            elig1;
    logic            idle_id;
    logic            bus_ready;
    logic            bus_err;
    logic [DW-1:0]   bus_rdata;
    logic            finish;
    logic            start_go;
    logic            start_id;
    logic            start_we;
    logic [AW-1:0]   start_addr;
    logic [DW-1:0]   start_wdata;

    always_comb begin
        // a requester whose done is about to show still holds req; keep it out
        elig0 = req0 && !(done_pend && !pend_id);
        elig1 = req1 && !(done_pend && pend_id);
        idle_id = (elig0 && elig1) ? ~rr : elig1;

        bus_ready = paddr[AW-1] ? pready2  : pready1;
        bus_err   = paddr[AW-1] ? pslverr2 : pslverr1;
        bus_rdata = paddr[AW-1] ? prdata2  : prdata1;

        finish = (state == ACCESS) && (bus_ready || (cnt == '0));

        if (state == ACCESS) begin
            start_id = ~gnt;
            start_go = finish && (gnt ? req0 : req1);
        end else begin
            start_id = idle_id;
            start_go = (state == IDLE) && (elig0 || elig1);
        end

        start_we    = start_id ? we1    : we0;
        start_addr  = start_id ? addr1  : addr0;
        start_wdata = start_id ? wdata1 : wdata0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            rr         <= 1'b1;
            cnt        <= '0;
            done_pend  <= 1'b0;
            pend_id    <= 1'b0;
            pend_err   <= 1'b0;
            pend_rd    <= 1'b0;
            pend_rdata <= '0;
            done0      <= 1'b0;
            err0       <= 1'b0;
            rdata0     <= '0;
            done1      <= 1'b0;
            err1       <= 1'b0;
            rdata1     <= '0;
            psel1      <= 1'b0;
            psel2      <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
        end else begin
            done0     <= 1'b0;
            err0      <= 1'b0;
            done1     <= 1'b0;
            err1      <= 1'b0;
            done_pend <= 1'b0;

            if (done_pend) begin
                if (pend_id) begin
                    done1 <= 1'b1;
                    err1  <= pend_err;
                    if (pend_rd) rdata1 <= pend_rdata;
                end else begin
                    done0 <= 1'b1;
                    err0  <= pend_err;
                    if (pend_rd) rdata0 <= pend_rdata;
                end
            end

            case (state)
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= CW'(TIMEOUT - 1);
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (finish) begin
                        done_pend  <= 1'b1;
                        pend_id    <= gnt;
                        pend_err   <= !bus_ready || bus_err;
                        pend_rd    <= bus_ready && !pwrite;
                        pend_rdata <= bus_rdata;
                        psel1      <= 1'b0;
                        psel2      <= 1'b0;
                        penable    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase

            // new grant, either from IDLE or back-to-back out of ACCESS
            if (start_go) begin
                gnt     <= start_id;
                paddr   <= start_addr;
                pwrite  <= start_we;
                pwdata  <= start_wdata;
                psel1   <= !start_addr[AW-1];
                psel2   <= start_addr[AW-1];
                penable <= 1'b0;
                state   <= SETUP;
                if (state == IDLE && elig0 && elig1) rr <= start_id;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-level model of grant order, bus
// timing and completion results, driven by directed and random rounds.
module tb_apb_master_arbiter;

    localparam int AW      = 9;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b1;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, err0, done1, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          psel1, psel2, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready1, pready2, pslverr1, pslverr2;
    logic [DW-1:0] prdata1, prdata2;

    apb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .err1(err1), .rdata1(rdata1),
        .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready1(pready1), .pready2(pready2),
        .prdata1(prdata1), .prdata2(prdata2),
        .pslverr1(pslverr1), .pslverr2(pslverr2)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference state: arbitration pointer and last returned read data
    logic          rr_m;
    logic [DW-1:0] rd_m [2];

    logic          t_we    [2];
    logic [AW-1:0] t_addr  [2];
    logic [DW-1:0] t_wdata [2];
    logic [DW-1:0] t_prd   [2];
    logic          t_perr  [2];
    int            t_waits [2];

    task automatic set_req(input int r, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int waits,
                           input logic [DW-1:0] prd, input logic perr);
        t_we[r] = we; t_addr[r] = a; t_wdata[r] = d;
        t_waits[r] = waits; t_prd[r] = prd; t_perr[r] = perr;
    endtask

    task automatic rand_slaves;
        pready1  = 1'($urandom_range(0, 1));
        pready2  = 1'($urandom_range(0, 1));
        pslverr1 = 1'($urandom_range(0, 1));
        pslverr2 = 1'($urandom_range(0, 1));
        prdata1  = DW'($urandom_range(0, 255));
        prdata2  = DW'($urandom_range(0, 255));
    endtask

    // Must be called just after a negedge: requests rise now, get sampled at the next edge.
    task automatic run_round(input bit en0, input bit en1);
        int ord [2];
        int s_exp [2];
        int d_exp [2];
        int seen [2];
        bit tmo [2];
        bit en [2];
        int nt, s, len, setups, acc, r, limit;
        bit rdy, dn, er;
        logic [DW-1:0] rd;
        logic [AW-1:0] cur_addr;

        en[0] = en0; en[1] = en1;
        seen[0] = 0; seen[1] = 0; tmo[0] = 0; tmo[1] = 0;
        d_exp[0] = 0; d_exp[1] = 0; s_exp[0] = 0; s_exp[1] = 0;
        ord[1] = 0;
        cur_addr = '0;

        if (en0 && en1) begin
            ord[0] = rr_m ? 0 : 1;
            ord[1] = 1 - ord[0];
            rr_m   = (ord[0] == 1);
            nt     = 2;
        end else begin
            ord[0] = en1 ? 1 : 0;
            nt     = 1;
        end

        we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wdata[0];
        we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wdata[1];
        req0 = en0; req1 = en1;

        // SETUP at the sampling edge, L ACCESS cycles, done one cycle after completion
        s = cyc + 1;
        for (int i = 0; i < nt; i++) begin
            r        = ord[i];
            tmo[r]   = (t_waits[r] >= TIMEOUT);
            len      = tmo[r] ? TIMEOUT : t_waits[r] + 1;
            s_exp[i] = s;
            d_exp[r] = s + 2 + len;
            s        = s + 1 + len;
        end
        limit  = s + 6;
        setups = 0;
        acc    = 0;

        while (cyc < limit) begin
            @(negedge pclk);
            if ((psel1 || psel2) && !penable) begin
                if (setups < nt) begin
                    r = ord[setups];
                    check("setup_cycle", cyc, s_exp[setups]);
                    check("paddr", 32'(paddr), 32'(t_addr[r]));
                    check("pwrite", 32'(pwrite), 32'(t_we[r]));
                    check("pwdata", 32'(pwdata), 32'(t_wdata[r]));
                    check("psel", {psel2, psel1}, t_addr[r][AW-1] ? 32'd2 : 32'd1);
                end
                setups++;
                cur_addr = paddr;
                acc = 0;
            end
            if (penable) begin
                acc++;
                check("paddr_hold", 32'(paddr), 32'(cur_addr));
            end

            for (int q = 0; q < 2; q++) begin
                dn = q ? done1 : done0;
                er = q ? err1 : err0;
                rd = q ? rdata1 : rdata0;
                if (dn) begin
                    if (en[q] && seen[q] == 0) begin
                        if (!t_we[q] && !tmo[q]) rd_m[q] = t_prd[q];
                        check($sformatf("done%0d_cycle", q), cyc, d_exp[q]);
                        check($sformatf("err%0d", q), 32'(er), 32'(tmo[q] || t_perr[q]));
                        check($sformatf("rdata%0d", q), 32'(rd), 32'(rd_m[q]));
                    end
                    seen[q]++;
                    if (q == 0) req0 = 1'b0; else req1 = 1'b0;
                end else begin
                    check($sformatf("err%0d_idle", q), 32'(er), 32'd0);
                end
            end

            rand_slaves();
            if (penable) begin
                rdy = 1'b0;
                if (setups >= 1 && setups <= nt) begin
                    r   = ord[setups-1];
                    rdy = (acc > t_waits[r]);
                end
                if (psel2) begin
                    pready2 = rdy;
                    if (rdy) begin prdata2 = t_prd[r]; pslverr2 = t_perr[r]; end
                end else begin
                    pready1 = rdy;
                    if (rdy) begin prdata1 = t_prd[r]; pslverr1 = t_perr[r]; end
                end
            end
        end

        check("setup_count", setups, nt);
        check("done0_count", seen[0], 32'(en[0]));
        check("done1_count", seen[1], 32'(en[1]));
        check("bus_idle", {psel1, psel2, penable}, 32'd0);
    endtask

    task automatic reset_mid_access;
        pready1 = 1'b0; pready2 = 1'b0;
        set_req(0, 1'b1, 9'h0F0, 8'h5A, 0, 8'h00, 1'b0);
        we0 = 1'b1; addr0 = 9'h0F0; wdata0 = 8'h5A;
        req0 = 1'b1;
        for (int i = 0; i < 10 && !penable; i++) @(negedge pclk);
        check("rst_reach_access", 32'(penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        check("rst_async_bus", {psel1, psel2, penable, done0, done1, err0}, 32'd0);
        check("rst_async_rdata", {rdata0, rdata1}, 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        rr_m = 1'b1; rd_m[0] = '0; rd_m[1] = '0;
        run_round(1'b1, 1'b0);
    endtask

    initial begin
        int e, w;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pready1 = 0; pready2 = 0; pslverr1 = 0; pslverr2 = 0;
        prdata1 = '0; prdata2 = '0;
        rr_m = 1'b1; rd_m[0] = '0; rd_m[1] = '0;
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, '0, '0, 0, '0, 1'b0);

        #1 presetn = 1'b0;
        #1;
        check("rst_ctrl", {done0, done1, err0, err1, psel1, psel2, penable, pwrite}, 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", 32'(pwdata), 32'd0);
        check("rst_rdata", {rdata0, rdata1}, 32'd0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;

        set_req(0, 1'b1, 9'h005, 8'hA5, 0, 8'h77, 1'b0);
        run_round(1'b1, 1'b0);

        set_req(1, 1'b0, 9'h10A, 8'h00, 3, 8'h3C, 1'b0);
        run_round(1'b0, 1'b1);

        set_req(0, 1'b0, 9'h033, 8'h11, 1, 8'hC3, 1'b0);
        set_req(1, 1'b1, 9'h1E4, 8'h22, 0, 8'h99, 1'b0);
        run_round(1'b1, 1'b1);
        set_req(0, 1'b1, 9'h144, 8'h33, 0, 8'h12, 1'b0);
        set_req(1, 1'b0, 9'h0AA, 8'h44, 2, 8'h6E, 1'b0);
        run_round(1'b1, 1'b1);

        set_req(0, 1'b0, 9'h042, 8'h00, 1000, 8'hEE, 1'b0);
        run_round(1'b1, 1'b0);

        set_req(1, 1'b1, 9'h1F0, 8'h81, 1, 8'h00, 1'b1);
        run_round(1'b0, 1'b1);
        set_req(0, 1'b0, 9'h00F, 8'h00, 0, 8'h5D, 1'b0);
        run_round(1'b1, 1'b0);

        set_req(0, 1'b0, 9'h155, 8'h00, TIMEOUT - 1, 8'hB2, 1'b0);
        run_round(1'b1, 1'b0);

        reset_mid_access();

        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) begin
                w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3)
                                                : $urandom_range(0, 4);
                set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 511)),
                        DW'($urandom_range(0, 255)), w, DW'($urandom_range(0, 255)),
                        1'($urandom_range(0, 5) == 0));
            end
            e = $urandom_range(1, 3);
            run_round(e[0], e[1]);
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
